// File: rtl/prog_clock_divider.sv
// prog_clock_divider
//   Multi-channel programmable frequency divider. Every channel counts
//   enabled clk cycles and, once per period of D+1 cycles, raises a
//   one-cycle tick strobe and toggles a 50%-duty square wave. A new divide
//   value is first written into a per-channel shadow register. It is copied
//   into the active register at the next period boundary, or at once while
//   the channel is disabled, so a running period is never cut short.
//   Everything runs on the rising edge of clk and every output is a
//   register. The block generates no derived clocks.
//
// Parameters
//   WIDTH    width of the divide value and of each channel counter
//   CH       number of independent channels (>= 1)
//   CHW      channel-index width, max(1, clog2(CH)); derived, not overridable
//
// Ports
//   clk      system clock
//   rst      asynchronous, active-high reset
//   en       per-channel run enable
//   wr_en    write strobe for the divide-value port
//   wr_ch    channel addressed by the write (indices >= CH are ignored)
//   wr_div   new divide value D (period = D+1 enabled cycles)
//   tick     one-cycle strobe at each period boundary
//   wave     square wave, toggles at each period boundary
//   pending  shadow value written but not yet applied
module prog_clock_divider #(
  parameter  int WIDTH = 8,
  parameter  int CH    = 2,
  localparam int CHW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    en,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_div,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    wave,
  output logic [CH-1:0]    pending
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act;
    logic [WIDTH-1:0] shd;
    logic             pend;
    logic             tick_q;
    logic             wave_q;
    logic             hit;
    logic             bnd;

    // The decode only matches indices 0..CH-1. An out-of-range wr_ch
    // therefore matches no channel and causes no state change.
    assign hit = wr_en && (wr_ch == CHW'(i));
    assign bnd = (cnt == act);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt    <= '0;
        act    <= '1;
        shd    <= '1;
        pend   <= 1'b0;
        tick_q <= 1'b0;
        wave_q <= 1'b0;
      end else begin
        if (en[i]) begin
          if (bnd) begin
            cnt    <= '0;
            tick_q <= 1'b1;
            wave_q <= ~wave_q;
            if (pend) begin
              act  <= shd;
              pend <= 1'b0;
            end
          end else begin
            cnt    <= cnt + WIDTH'(1);
            tick_q <= 1'b0;
          end
        end else begin
          // A disabled channel discards its partial period and takes any
          // pending value right away. The wave level is held.
          cnt    <= '0;
          tick_q <= 1'b0;
          if (pend) begin
            act  <= shd;
            pend <= 1'b0;
          end
        end
        // The write comes after the apply logic so that it wins on the same
        // edge. The apply above still uses the shd and pend values from
        // before this edge, so a write that lands on a boundary takes
        // effect at the following boundary.
        if (hit) begin
          shd  <= wr_div;
          pend <= 1'b1;
        end
      end
    end

    assign tick[i]    = tick_q;
    assign wave[i]    = wave_q;
    assign pending[i] = pend;
  end

endmodule
